// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the ALU control-step sequencer.
//   - ALU opcode encodings
//   - sequencer state enum
//   - op-class helpers: is_unary, is_wide, is_supported
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int REG_IDX_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b01001;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TY   = 3'd1,  // first operand into Y
    S_TOP  = 3'd2,  // ALU operates, result into Z
    S_TLO  = 3'd3,  // Z low half written back
    S_THI  = 3'd4   // Z high half written back (wide ops only)
  } state_t;

  function automatic logic is_binary(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  endfunction

  function automatic logic is_unary(input logic [OPC_W-1:0] opc);
    return (opc == OP_NEG) || (opc == OP_NOT);
  endfunction

  function automatic logic is_wide(input logic [OPC_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

  function automatic logic is_supported(input logic [OPC_W-1:0] opc);
    return is_binary(opc) || is_unary(opc) || is_wide(opc);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: 4-bit index to NREG-wide one-hot decoder with enable.
//   en   in  1          : when low, every output bit is 0
//   idx  in  4          : bit to set; indices >= NREG set nothing
//   dec  out NREG       : one-hot result
module onehot_dec #(
  parameter int NREG = 16
) (
  input  logic            en,
  input  logic [3:0]      idx,
  output logic [NREG-1:0] dec
);

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign dec[i] = en && (32'(idx) == i);
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps data_path through one ALU instruction at a time.
//   Clock                in  1    : rising-edge clock
//   clear                in  1    : async active-low reset
//   start                in  1    : instruction valid, sampled in IDLE only
//   opcode/ra/rb/rc      in  5/4/4/4 : decoded instruction
//   busy, done, err      out 1    : handshake / status
//   op                   out 5    : latched ALU select
//   Rout, Rin            out NREG : one-hot register drive / load strobes
//   Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin out 1 : datapath strobes
// Every output is a flop loaded from values decoded off the next state, so a
// strobe is stable for the whole cycle in which its state is current.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            start,
  input  logic [4:0]      opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [4:0]      op,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic            Yin,
  output logic            Zhighin,
  output logic            Zlowin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            LOin
);

  state_t     state, nstate;
  logic [3:0] ra_q, rb_q, rc_q;

  // In IDLE the fields about to be latched come straight from the inputs so
  // the first step's strobes can be decoded on the acceptance edge.
  logic       in_idle;
  logic [4:0] sel_op;
  logic [3:0] sel_ra, sel_rb, sel_rc;
  logic       accept, reject;

  assign in_idle = (state == S_IDLE);
  assign sel_op  = in_idle ? opcode : op;
  assign sel_ra  = in_idle ? ra : ra_q;
  assign sel_rb  = in_idle ? rb : rb_q;
  assign sel_rc  = in_idle ? rc : rc_q;
  assign accept  = in_idle && start &&  is_supported(opcode);
  assign reject  = in_idle && start && !is_supported(opcode);

  // next state
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (accept) nstate = is_unary(opcode) ? S_TOP : S_TY;
      S_TY:   nstate = S_TOP;
      S_TOP:  nstate = S_TLO;
      S_TLO:  nstate = is_wide(op) ? S_THI : S_IDLE;
      S_THI:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // strobe decode from next state
  logic            rout_en_n, rin_en_n;
  logic [3:0]      rout_idx_n, rin_idx_n;
  logic            yin_n, zhin_n, zlin_n, zhout_n, zlout_n, hiin_n, loin_n;
  logic            done_n;
  logic [NREG-1:0] rout_n, rin_n;

  always_comb begin
    rout_en_n  = 1'b0;
    rout_idx_n = '0;
    rin_en_n   = 1'b0;
    rin_idx_n  = '0;
    yin_n      = 1'b0;
    zhin_n     = 1'b0;
    zlin_n     = 1'b0;
    zhout_n    = 1'b0;
    zlout_n    = 1'b0;
    hiin_n     = 1'b0;
    loin_n     = 1'b0;
    done_n     = 1'b0;
    case (nstate)
      S_TY: begin
        rout_en_n  = 1'b1;
        rout_idx_n = sel_rb;
        yin_n      = 1'b1;
      end
      S_TOP: begin
        // unary ops have no Y cycle: their sole operand goes on the bus here
        rout_en_n  = 1'b1;
        rout_idx_n = is_unary(sel_op) ? sel_rb : sel_rc;
        zhin_n     = 1'b1;
        zlin_n     = 1'b1;
      end
      S_TLO: begin
        zlout_n = 1'b1;
        if (is_wide(sel_op)) begin
          loin_n = 1'b1;
        end else begin
          rin_en_n  = 1'b1;
          rin_idx_n = sel_ra;
          done_n    = 1'b1;
        end
      end
      S_THI: begin
        zhout_n = 1'b1;
        hiin_n  = 1'b1;
        done_n  = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec #(.NREG(NREG)) u_rout_dec (
    .en  (rout_en_n),
    .idx (rout_idx_n),
    .dec (rout_n)
  );

  onehot_dec #(.NREG(NREG)) u_rin_dec (
    .en  (rin_en_n),
    .idx (rin_idx_n),
    .dec (rin_n)
  );

  // state, latched instruction, registered outputs
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      op       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      Rout     <= '0;
      Rin      <= '0;
      Yin      <= 1'b0;
      Zhighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighout <= 1'b0;
      Zlowout  <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        op   <= opcode;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      busy     <= (nstate != S_IDLE);
      done     <= done_n;
      err      <= reject;
      Rout     <= rout_n;
      Rin      <= rin_n;
      Yin      <= yin_n;
      Zhighin  <= zhin_n;
      Zlowin   <= zlin_n;
      Zhighout <= zhout_n;
      Zlowout  <= zlout_n;
      HIin     <= hiin_n;
      LOin     <= loin_n;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed instructions, strobe timing checked per
// cycle, and a small behavioural data_path driven by the strobes to confirm
// the register results.
module tb_alu_sequencer;

  localparam int NREG = 16;

  logic            Clock = 1'b0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic [4:0]      opcode = '0;
  logic [3:0]      ra = '0, rb = '0, rc = '0;
  logic            busy, done, err;
  logic [4:0]      op;
  logic [NREG-1:0] Rout, Rin;
  logic            Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin;

  int n_chk = 0;
  int n_fail = 0;

  alu_sequencer #(.NREG(NREG)) dut (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .err(err),
    .op(op), .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zhighin(Zhighin),
    .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin)
  );

  always #5 Clock = ~Clock;

  // {busy,done,err,Yin,Zhighin,Zlowin,Zhighout,Zlowout,HIin,LOin}
  logic [9:0] strb;
  assign strb = {busy, done, err, Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin};

  // behavioural data_path
  logic [31:0] rf [NREG];
  logic [31:0] Y, LO, HI, bus;
  logic [63:0] Z;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always_comb begin
    bus = '0;
    for (int i = 0; i < NREG; i++) if (Rout[i]) bus = bus | rf[i];
    if (Zlowout)  bus = bus | Z[31:0];
    if (Zhighout) bus = bus | Z[63:32];
  end

  function automatic logic [63:0] alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b01001: return {32'd0, -b};
      5'b01010: return {32'd0, ~b};
      5'b01111: return {32'd0, a} * {32'd0, b};
      5'b10000: return {a % b, a / b};
      default:  return 64'd0;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    if (Yin) Y <= bus;
    if (Zlowin) Z <= alu(op, Y, bus);
    for (int i = 0; i < NREG; i++) if (Rin[i]) rf[i] <= bus;
    if (LOin) LO <= bus;
    if (HIin) HI <= bus;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [3:0] i, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = i; pl_val = v;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    tick(); tick(); tick();
    n_chk++;
    if (strb !== 10'b0 || Rout !== '0 || Rin !== '0 || op !== 5'b0) begin
      n_fail++;
      $display("FAIL reset strb=%b Rout=%h Rin=%h op=%b, want all 0", strb, Rout, Rin, op);
    end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_add();
    preload(4'd2, 32'd12);
    preload(4'd3, 32'd5);
    opcode = 5'b00011; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b1001000000 || Rout !== 16'h0004 || Rin !== 16'h0000) begin
      n_fail++;
      $display("FAIL add_k1 strb=%b Rout=%h Rin=%h want 1001000000/0004/0000", strb, Rout, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1000110000 || Rout !== 16'h0008 || Rin !== 16'h0000) begin
      n_fail++;
      $display("FAIL add_k2 strb=%b Rout=%h Rin=%h want 1000110000/0008/0000", strb, Rout, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rout !== 16'h0000 || Rin !== 16'h0002 || op !== 5'b00011) begin
      n_fail++;
      $display("FAIL add_k3 strb=%b Rout=%h Rin=%h op=%b want 1100000100/0000/0002/00011", strb, Rout, Rin, op);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0 || rf[1] !== 32'd17) begin
      n_fail++;
      $display("FAIL add_result strb=%b R1=%0d want 0/17", strb, rf[1]);
    end
  endtask

  task automatic test_neg();
    preload(4'd2, 32'd5);
    opcode = 5'b01001; ra = 4'd1; rb = 4'd2; rc = 4'd9; start = 1'b1;
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b1000110000 || Rout !== 16'h0004 || op !== 5'b01001) begin
      n_fail++;
      $display("FAIL neg_k1 strb=%b Rout=%h op=%b want 1000110000/0004/01001", strb, Rout, op);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rin !== 16'h0002 || Rout !== 16'h0000 || op !== 5'b01001) begin
      n_fail++;
      $display("FAIL neg_k2 strb=%b Rin=%h Rout=%h op=%b want 1100000100/0002/0000/01001", strb, Rin, Rout, op);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0 || rf[1] !== 32'hFFFF_FFFB || op !== 5'b01001) begin
      n_fail++;
      $display("FAIL neg_result strb=%b R1=%h op=%b want 0/fffffffb/01001", strb, rf[1], op);
    end
  endtask

  task automatic test_mul();
    preload(4'd2, 32'd12);
    opcode = 5'b01111; ra = 4'd5; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b1001000000 || Rout !== 16'h0004) begin
      n_fail++;
      $display("FAIL mul_k1 strb=%b Rout=%h want 1001000000/0004", strb, Rout);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1000110000 || Rout !== 16'h0008) begin
      n_fail++;
      $display("FAIL mul_k2 strb=%b Rout=%h want 1000110000/0008", strb, Rout);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1000000101 || Rout !== '0 || Rin !== '0) begin
      n_fail++;
      $display("FAIL mul_k3 strb=%b Rout=%h Rin=%h want 1000000101/0000/0000", strb, Rout, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1100001010 || Rout !== '0 || Rin !== '0) begin
      n_fail++;
      $display("FAIL mul_k4 strb=%b Rout=%h Rin=%h want 1100001010/0000/0000", strb, Rout, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0 || LO !== 32'd60 || HI !== 32'd0) begin
      n_fail++;
      $display("FAIL mul_result strb=%b LO=%0d HI=%0d want 0/60/0", strb, LO, HI);
    end
  endtask

  task automatic test_err();
    opcode = 5'b11111; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b0010000000 || Rout !== '0 || Rin !== '0 || op !== 5'b01111) begin
      n_fail++;
      $display("FAIL err_k1 strb=%b Rout=%h Rin=%h op=%b want 0010000000/0000/0000/01111", strb, Rout, Rin, op);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0) begin
      n_fail++;
      $display("FAIL err_k2 strb=%b want 0", strb);
    end
    opcode = 5'b00011; ra = 4'd4; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rin !== 16'h0010) begin
      n_fail++;
      $display("FAIL err_add_k3 strb=%b Rin=%h want 1100000100/0010", strb, Rin);
    end
    tick();
    n_chk++;
    if (rf[4] !== 32'd17) begin
      n_fail++;
      $display("FAIL err_add_result R4=%0d want 17", rf[4]);
    end
  endtask

  task automatic test_back_to_back();
    opcode = 5'b00011; ra = 4'd7; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick();
    n_chk++;
    if (strb !== 10'b1001000000) begin
      n_fail++;
      $display("FAIL b2b_k1 strb=%b want 1001000000", strb);
    end
    ra = 4'd8;  // must not disturb the instruction in flight
    tick();
    n_chk++;
    if (strb !== 10'b1000110000 || Rout !== 16'h0008) begin
      n_fail++;
      $display("FAIL b2b_k2 strb=%b Rout=%h want 1000110000/0008", strb, Rout);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rin !== 16'h0080) begin
      n_fail++;
      $display("FAIL b2b_k3 strb=%b Rin=%h want 1100000100/0080", strb, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0 || Rout !== '0) begin
      n_fail++;
      $display("FAIL b2b_k4 strb=%b Rout=%h want 0/0000", strb, Rout);
    end
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b1001000000 || Rout !== 16'h0004) begin
      n_fail++;
      $display("FAIL b2b_k5 strb=%b Rout=%h want 1001000000/0004", strb, Rout);
    end
    tick(); tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rin !== 16'h0100) begin
      n_fail++;
      $display("FAIL b2b_second_wb strb=%b Rin=%h want 1100000100/0100", strb, Rin);
    end
    tick();
    n_chk++;
    if (strb !== 10'b0 || rf[7] !== 32'd17 || rf[8] !== 32'd17) begin
      n_fail++;
      $display("FAIL b2b_result strb=%b R7=%0d R8=%0d want 0/17/17", strb, rf[7], rf[8]);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 5'b01111; ra = 4'd0; rb = 4'd2; rc = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    n_chk++;
    if (strb !== 10'b1000110000) begin
      n_fail++;
      $display("FAIL rmid_k2 strb=%b want 1000110000", strb);
    end
    #2 clear = 1'b0;
    #1;
    n_chk++;
    if (strb !== 10'b0 || Rout !== '0 || Rin !== '0 || op !== 5'b0) begin
      n_fail++;
      $display("FAIL rmid_async strb=%b Rout=%h Rin=%h op=%b want all 0", strb, Rout, Rin, op);
    end
    tick(); tick();
    clear = 1'b1;
    tick();
    n_chk++;
    if (strb !== 10'b0 || Rout !== '0 || Rin !== '0) begin
      n_fail++;
      $display("FAIL rmid_after strb=%b Rout=%h Rin=%h want all 0", strb, Rout, Rin);
    end
    opcode = 5'b01010; ra = 4'd6; rb = 4'd3; rc = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    n_chk++;
    if (strb !== 10'b1000110000 || Rout !== 16'h0008) begin
      n_fail++;
      $display("FAIL rmid_not_k1 strb=%b Rout=%h want 1000110000/0008", strb, Rout);
    end
    tick();
    n_chk++;
    if (strb !== 10'b1100000100 || Rin !== 16'h0040) begin
      n_fail++;
      $display("FAIL rmid_not_k2 strb=%b Rin=%h want 1100000100/0040", strb, Rin);
    end
    tick();
    n_chk++;
    if (rf[6] !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL rmid_not_result R6=%h want fffffffa", rf[6]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_neg();
    test_mul();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
